mux3_rr_sel: RTL and testbench

Round-robin select sequencer that sits directly upstream of the 3:1 mux and drives its s1/s0 select lines.
- Arbitrates three requesters (i0, i1, i2 sources).
- Holds a grant until the transfer ends, then rotates priority.
- Presents a registered, glitch-free 2-bit select, with a matching one-hot grant back to the sources.

---
 rtl/mux3_rr_pkg.sv | 34 +++
 rtl/mux3_rr_sel_pick.sv | 35 +++
 rtl/mux3_rr_sel.sv | 113 +++++++++++
 tb/tb_mux3_rr_sel.sv | 139 +++++++++++++
 4 files changed

// File: rtl/mux3_rr_pkg.sv
// Shared constants, state type and select helpers for the 3-input round-robin select sequencer.
package mux3_rr_pkg;

  localparam int unsigned NUM_IN = 3;

  localparam logic [1:0] SEL_I0 = 2'b00;
  localparam logic [1:0] SEL_I1 = 2'b01;
  localparam logic [1:0] SEL_I2 = 2'b10;

  typedef enum logic {IDLE, GRANT} state_e;

  // One-hot grant to mux select; an empty grant parks the mux on i0.
  function automatic logic [1:0] onehot_to_sel(input logic [NUM_IN-1:0] oh);
    logic [1:0] s;
    case (oh)
      3'b010:  s = SEL_I1;
      3'b100:  s = SEL_I2;
      default: s = SEL_I0;
    endcase
    return s;
  endfunction

  // Pointer value that follows a given granted index, wrapping 2 -> 0.
  function automatic logic [1:0] ptr_after(input logic [NUM_IN-1:0] oh);
    logic [1:0] p;
    case (oh)
      3'b001:  p = 2'd1;
      3'b010:  p = 2'd2;
      default: p = 2'd0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/mux3_rr_sel_pick.sv
// rr_pick3: combinational round-robin pick of the first request at or above ptr, wrapping 2 -> 0.
module rr_pick3
  import mux3_rr_pkg::*;
(
  input  logic [NUM_IN-1:0] req,
  input  logic [1:0]        ptr,
  output logic [NUM_IN-1:0] pick,
  output logic              any_req
);

  logic [1:0] start;
  logic [1:0] idx;
  logic       found;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 2'd0;
    // ptr never holds 3; treat it as 0 defensively.
    start = (ptr == 2'd3) ? 2'd0 : ptr;
    for (int k = 0; k < 3; k++) begin
      case (start)
        2'd1:    idx = (k == 0) ? 2'd1 : (k == 1) ? 2'd2 : 2'd0;
        2'd2:    idx = (k == 0) ? 2'd2 : (k == 1) ? 2'd0 : 2'd1;
        default: idx = 2'(k);
      endcase
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    any_req = |req;
  end

endmodule

// File: rtl/mux3_rr_sel.sv
// Round-robin select sequencer driving the s1/s0 lines of a 3:1 mux with a matching one-hot grant.
// Optional forced release after TIMEOUT held cycles is enabled by defining MUX3_RR_TIMEOUT_EN.
module mux3_rr_sel
  import mux3_rr_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] req,
  input  logic              last,
  output logic [NUM_IN-1:0] gnt,
  output logic              s1,
  output logic              s0,
  output logic              busy,
  output logic              timeout
);

  state_e            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [NUM_IN-1:0] gnt_q, gnt_d;
  logic [1:0]        sel_q;
  logic              busy_q;
  logic              to_q, to_d;

  logic [NUM_IN-1:0] arb_req, pick;
  logic [1:0]        arb_ptr;
  logic              any_req;
  logic              normal_rel, force_rel, new_gnt;

  rr_pick3 u_pick (
    .req     (arb_req),
    .ptr     (arb_ptr),
    .pick    (pick),
    .any_req (any_req)
  );

`ifdef MUX3_RR_TIMEOUT_EN
  logic [7:0] cnt_q;
  assign force_rel = (state_q == GRANT) && (cnt_q == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst)                  cnt_q <= '0;
    else if (new_gnt)         cnt_q <= '0;
    else if (state_q == GRANT) cnt_q <= cnt_q + 8'd1;
  end
`else
  // No hold limit; the parameter term only keeps TIMEOUT referenced.
  assign force_rel = 1'b0 & (TIMEOUT > 255);
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    to_d       = 1'b0;
    new_gnt    = 1'b0;
    arb_req    = req;
    arb_ptr    = ptr_q;
    normal_rel = last | ~|(req & gnt_q);
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          gnt_d   = pick;
          new_gnt = 1'b1;
        end
      end
      GRANT: begin
        if (normal_rel || force_rel) begin
          // Re-arbitrate this cycle from the rotated pointer; a finished source
          // is masked so a lone requester sees one idle cycle before regrant.
          ptr_d   = ptr_after(gnt_q);
          arb_ptr = ptr_d;
          arb_req = (last || force_rel) ? (req & ~gnt_q) : req;
          gnt_d   = any_req ? pick : '0;
          state_d = any_req ? GRANT : IDLE;
          new_gnt = any_req;
          to_d    = force_rel & ~normal_rel;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      gnt_q   <= '0;
      sel_q   <= SEL_I0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      sel_q   <= onehot_to_sel(gnt_d);
      busy_q  <= |gnt_d;
      to_q    <= to_d;
    end
  end

  assign gnt     = gnt_q;
  assign s1      = sel_q[1];
  assign s0      = sel_q[0];
  assign busy    = busy_q;
  assign timeout = to_q;

endmodule

// File: tb/tb_mux3_rr_sel.sv
// Directed bench for mux3_rr_sel: vector table for arbitration sequences plus hand-written
// multi-cycle sequences for the single-source gap and the hold timeout.
module tb_mux3_rr_sel;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic       last;
  logic [2:0] gnt;
  logic       s1, s0, busy, timeout;

  int checks   = 0;
  int failures = 0;

  mux3_rr_sel #(.TIMEOUT(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .last    (last),
    .gnt     (gnt),
    .s1      (s1),
    .s0      (s0),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // Expected observation packed as {gnt, s1, s0, busy, timeout}.
  localparam logic [6:0] E_IDLE  = 7'b000_00_0_0;
  localparam logic [6:0] E_G0    = 7'b001_00_1_0;
  localparam logic [6:0] E_G1    = 7'b010_01_1_0;
  localparam logic [6:0] E_G2    = 7'b100_10_1_0;
  localparam logic [6:0] E_G1_TO = 7'b010_01_1_1;

  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic       last;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[20];

  task automatic step(input logic r, input logic [2:0] q, input logic l);
    @(negedge clk);
    rst  = r;
    req  = q;
    last = l;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [6:0] exp);
    logic [6:0] got;
    got = {gnt, s1, s0, busy, timeout};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got gnt/sel/busy/to=%b required %b", nm, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold;
    rst = 1'b1; req = 3'b000; last = 1'b0;

    tbl[0]  = '{1'b1, 3'b111, 1'b0, E_IDLE};  // reset with requests pending
    tbl[1]  = '{1'b1, 3'b111, 1'b0, E_IDLE};
    tbl[2]  = '{1'b0, 3'b111, 1'b0, E_G0};    // first edge after reset: ptr=0
    tbl[3]  = '{1'b0, 3'b111, 1'b1, E_G1};    // rotation, no bubble
    tbl[4]  = '{1'b0, 3'b111, 1'b1, E_G2};
    tbl[5]  = '{1'b0, 3'b111, 1'b1, E_G0};    // wrap 2 -> 0
    tbl[6]  = '{1'b0, 3'b111, 1'b1, E_G1};
    tbl[7]  = '{1'b0, 3'b111, 1'b0, E_G1};    // no preemption
    tbl[8]  = '{1'b0, 3'b111, 1'b0, E_G1};
    tbl[9]  = '{1'b0, 3'b111, 1'b0, E_G1};
    tbl[10] = '{1'b0, 3'b111, 1'b1, E_G2};    // last wins even at hold limit
    tbl[11] = '{1'b0, 3'b011, 1'b1, E_G0};
    tbl[12] = '{1'b0, 3'b010, 1'b0, E_G1};    // request drop releases without last
    tbl[13] = '{1'b0, 3'b010, 1'b1, E_IDLE};  // lone requester with last: gap
    tbl[14] = '{1'b0, 3'b010, 1'b1, E_G1};    // last ignored in idle
    tbl[15] = '{1'b0, 3'b000, 1'b0, E_IDLE};  // drop with nobody else -> idle
    tbl[16] = '{1'b0, 3'b000, 1'b0, E_IDLE};
    tbl[17] = '{1'b0, 3'b101, 1'b0, E_G2};    // ptr=2 after i1 released
    tbl[18] = '{1'b1, 3'b101, 1'b0, E_IDLE};  // reset mid-grant
    tbl[19] = '{1'b0, 3'b110, 1'b0, E_G1};    // ptr back to 0 after reset

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].last);
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Single source held, then a one-cycle gap before regrant.
`ifdef MUX3_RR_TIMEOUT_EN
    hold = 4;
`else
    hold = 5;
`endif
    step(1'b1, 3'b000, 1'b0);
    step(1'b1, 3'b000, 1'b0);
    chk("single_reset", E_IDLE);
    for (int c = 1; c <= hold; c++) begin
      step(1'b0, 3'b100, 1'b0);
      chk($sformatf("single_hold%0d", c), E_G2);
    end
    step(1'b0, 3'b100, 1'b1);
    chk("single_gap", E_IDLE);
    step(1'b0, 3'b100, 1'b0);
    chk("single_regrant", E_G2);

    // Hold limit: forced release after 4 grant cycles when enabled.
    step(1'b1, 3'b000, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      step(1'b0, 3'b011, 1'b0);
      chk($sformatf("to_hold%0d", c), E_G0);
    end
    step(1'b0, 3'b011, 1'b0);
`ifdef MUX3_RR_TIMEOUT_EN
    chk("to_release", E_G1_TO);
    step(1'b0, 3'b011, 1'b0);
    chk("to_after", E_G1);
`else
    chk("to_release", E_G0);
    step(1'b0, 3'b011, 1'b0);
    chk("to_after", E_G0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
